subckt_bist_sequencer: RTL and testbench

- Built-in self-test sequencer for one flop-based benchmark subcircuit under test (SUT), e.g. a 6-input, 2-flop-stage Nt_Node cone.
- Drives the SUT data inputs from a 16-bit LFSR, waits for the SUT register latency, then compacts the 1-bit SUT response into a 16-bit MISR.
- At the end of a run it compares the signature against a golden value, so trojan-modified subcircuits are flagged by signature mismatch.
- Sits between the trojan-detection test harness (start/config/result) and the SUT.

---
 rtl/subckt_bist_sequencer_if.sv | 28 ++
 rtl/subckt_bist_sequencer.sv | 116 +++++++++++
 tb/tb_subckt_bist_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/subckt_bist_sequencer_if.sv
// Harness/SUT-facing signal bundle for the BIST sequencer.
// The harness side uses the master modport; the sequencer itself uses slave.
interface subckt_bist_sequencer_if #(
    parameter int STIM_W = 6,
    parameter int CNT_W  = 10
);
    logic              start_i;
    logic              abort_i;
    logic [CNT_W-1:0]  num_patterns_i;
    logic [15:0]       seed_i;
    logic [15:0]       golden_i;
    logic              dut_resp_i;
    logic [STIM_W-1:0] stim_o;
    logic              busy_o;
    logic              done_o;
    logic              pass_o;
    logic [15:0]       signature_o;

    modport master (
        output start_i, abort_i, num_patterns_i, seed_i, golden_i, dut_resp_i,
        input  stim_o, busy_o, done_o, pass_o, signature_o
    );

    modport slave (
        input  start_i, abort_i, num_patterns_i, seed_i, golden_i, dut_resp_i,
        output stim_o, busy_o, done_o, pass_o, signature_o
    );
endinterface

// File: rtl/subckt_bist_sequencer.sv
// BIST sequencer: LFSR stimulus into one subcircuit under test, MISR compaction
// of its 1-bit response, and a golden-signature check at the end of each run.
module subckt_bist_sequencer #(
    parameter int STIM_W   = 6,
    parameter int PIPE_LAT = 2,
    parameter int CNT_W    = 10
) (
    input  logic I1470_clk,
    input  logic I1477_rst,
    subckt_bist_sequencer_if.slave bus
);
    localparam int WAIT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_APPLY,
        S_WAIT,
        S_CAPTURE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [15:0]       lfsr_reg;
    logic [15:0]       misr_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  num_reg;
    logic [WAIT_W-1:0] wait_reg;
    logic [STIM_W-1:0] stim_reg;
    logic              pass_reg;

    logic [15:0]       lfsr_next;
    logic [15:0]       misr_next;
    logic [STIM_W-1:0] stim_load;
    logic              abort_take;

    assign lfsr_next  = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    assign misr_next  = {misr_reg[14:0],
                         misr_reg[15] ^ misr_reg[13] ^ misr_reg[12] ^ misr_reg[10] ^ bus.dut_resp_i};
    assign abort_take = bus.abort_i && (state_reg != S_IDLE);

    // The SUT sees the low STIM_W bits of the LFSR.
    for (genvar gi = 0; gi < STIM_W; gi++) begin : g_stim
        assign stim_load[gi] = lfsr_reg[gi];
    end

    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (bus.start_i) state_next = S_LOAD;
            S_LOAD:    state_next = (bus.num_patterns_i == '0) ? S_CHECK : S_APPLY;
            S_APPLY:   state_next = S_WAIT;
            S_WAIT:    if (wait_reg == WAIT_W'(PIPE_LAT - 1)) state_next = S_CAPTURE;
            S_CAPTURE: state_next = (cnt_reg == num_reg - CNT_W'(1)) ? S_CHECK : S_APPLY;
            S_CHECK:   state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        if (abort_take) state_next = S_IDLE;
    end

    // Abort drops back to IDLE but leaves the MISR and the last pass result intact for debug.
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            lfsr_reg <= 16'h0001;
            misr_reg <= '0;
            cnt_reg  <= '0;
            num_reg  <= '0;
            wait_reg <= '0;
            stim_reg <= '0;
            pass_reg <= 1'b0;
        end else if (abort_take) begin
            stim_reg <= '0;
        end else begin
            case (state_reg)
                S_LOAD: begin
                    lfsr_reg <= (bus.seed_i == 16'h0000) ? 16'h0001 : bus.seed_i;
                    misr_reg <= '0;
                    cnt_reg  <= '0;
                    num_reg  <= bus.num_patterns_i;
                end
                S_APPLY: begin
                    stim_reg <= stim_load;
                    wait_reg <= '0;
                end
                S_WAIT: begin
                    if (wait_reg != WAIT_W'(PIPE_LAT - 1)) wait_reg <= wait_reg + WAIT_W'(1);
                end
                S_CAPTURE: begin
                    misr_reg <= misr_next;
                    lfsr_reg <= lfsr_next;
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                end
                S_CHECK: begin
                    pass_reg <= (misr_reg == bus.golden_i);
                end
                default: ;
            endcase
        end
    end

    assign bus.stim_o      = stim_reg;
    assign bus.busy_o      = (state_reg != S_IDLE);
    assign bus.done_o      = (state_reg == S_DONE);
    assign bus.pass_o      = pass_reg;
    assign bus.signature_o = misr_reg;
endmodule

// File: tb/tb_subckt_bist_sequencer.sv
// Directed and randomized runs of the BIST sequencer against a pattern-level
// model: expected stimulus list, signature and run length per run.
module tb_subckt_bist_sequencer;
    localparam int STIM_W   = 6;
    localparam int PIPE_LAT = 2;
    localparam int CNT_W    = 10;
    localparam int PER      = 2 + PIPE_LAT;

    logic I1470_clk = 1'b0;
    logic I1477_rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic resp_mem [0:63];

    subckt_bist_sequencer_if #(.STIM_W(STIM_W), .CNT_W(CNT_W)) bus ();

    subckt_bist_sequencer #(.STIM_W(STIM_W), .PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (
        .I1470_clk (I1470_clk),
        .I1477_rst (I1477_rst),
        .bus       (bus)
    );

    always #5 I1470_clk = ~I1470_clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] x, input logic r);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10] ^ r};
    endfunction

    function automatic logic [15:0] misr_of(input int n);
        logic [15:0] m = 16'h0000;
        for (int i = 0; i < n; i++) m = misr_step(m, resp_mem[i]);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stim"}, 32'(bus.stim_o), 32'h0);
        chk({tag, "_busy"}, 32'(bus.busy_o), 32'h0);
        chk({tag, "_done"}, 32'(bus.done_o), 32'h0);
        chk({tag, "_pass"}, 32'(bus.pass_o), 32'h0);
        chk({tag, "_sig"},  32'(bus.signature_o), 32'h0);
    endtask

    // One run; abort_at / rst_at name the cycle (start sample = cycle 0) in which
    // abort or reset is raised, or -1 for none.
    task automatic run(input string name, input logic [15:0] seed, input int n,
                       input logic [15:0] golden, input int abort_at, input int rst_at);
        logic [15:0]       s, m, m_part;
        logic [STIM_W-1:0] stim_exp [0:63];
        logic              pass_before;
        int                t;
        t = 3 + n * PER;
        s = (seed == 16'h0000) ? 16'h0001 : seed;
        for (int i = 0; i < n; i++) begin
            stim_exp[i] = s[STIM_W-1:0];
            s = lfsr_step(s);
        end
        m = misr_of(n);
        pass_before = bus.pass_o;
        bus.seed_i = seed;
        bus.num_patterns_i = CNT_W'(n);
        bus.golden_i = golden;
        bus.dut_resp_i = resp_mem[0];
        bus.start_i = 1'b1;
        for (int c = 1; c <= t + 1; c++) begin
            @(posedge I1470_clk);
            @(negedge I1470_clk);
            if (c == 1) bus.start_i = 1'b0;
            if (c >= 2 && (c - 2) / PER < n) bus.dut_resp_i = resp_mem[(c - 2) / PER];
            if (abort_at >= 0 && c == abort_at + 1) begin
                m_part = 16'h0000;
                for (int i = 0; i < n; i++)
                    if (1 + (i + 1) * PER < c) m_part = misr_step(m_part, resp_mem[i]);
                chk({name, "_abort_busy"}, 32'(bus.busy_o), 32'h0);
                chk({name, "_abort_done"}, 32'(bus.done_o), 32'h0);
                chk({name, "_abort_stim"}, 32'(bus.stim_o), 32'h0);
                chk({name, "_abort_pass"}, 32'(bus.pass_o), 32'(pass_before));
                chk({name, "_abort_sig"},  32'(bus.signature_o), 32'(m_part));
                bus.abort_i = 1'b0;
                $display("run %s seed=%h n=%0d aborted at cycle %0d", name, seed, n, abort_at);
                return;
            end
            if (rst_at >= 0 && c == rst_at + 1) begin
                chk_reset_outputs({name, "_midrst"});
                I1477_rst = 1'b0;
                $display("run %s seed=%h n=%0d reset at cycle %0d", name, seed, n, rst_at);
                return;
            end
            if (c <= t) begin
                chk({name, "_busy"}, 32'(bus.busy_o), 32'h1);
                chk({name, "_done"}, 32'(bus.done_o), 32'(c == t));
                if (c >= 3 && (c - 3) % PER == 0 && (c - 3) / PER < n)
                    chk({name, "_stim"}, 32'(bus.stim_o), 32'(stim_exp[(c - 3) / PER]));
                if (c == t) begin
                    chk({name, "_sig"},  32'(bus.signature_o), 32'(m));
                    chk({name, "_pass"}, 32'(bus.pass_o), 32'(m == golden));
                end
            end else begin
                chk({name, "_idle_busy"}, 32'(bus.busy_o), 32'h0);
                chk({name, "_idle_done"}, 32'(bus.done_o), 32'h0);
            end
            if (c == abort_at) bus.abort_i = 1'b1;
            if (c == rst_at)   I1477_rst = 1'b1;
        end
        $display("run %s seed=%h n=%0d golden=%h sig=%h pass=%0d", name, seed, n, golden,
                 bus.signature_o, bus.pass_o);
    endtask

    initial begin
        int          n;
        logic [15:0] seed, g;
        bus.start_i = 1'b1;
        bus.abort_i = 1'b0;
        bus.num_patterns_i = '0;
        bus.seed_i = '0;
        bus.golden_i = '0;
        bus.dut_resp_i = 1'b0;
        for (int i = 0; i < 64; i++) resp_mem[i] = 1'b0;

        // Reset held two cycles with start high: nothing may start.
        for (int k = 0; k < 2; k++) begin
            @(posedge I1470_clk);
            @(negedge I1470_clk);
            chk_reset_outputs("reset");
        end
        bus.start_i = 1'b0;
        I1477_rst = 1'b0;
        @(posedge I1470_clk);
        @(negedge I1470_clk);
        chk("post_reset_busy", 32'(bus.busy_o), 32'h0);
        $display("reset released, busy=%0d", bus.busy_o);

        for (int i = 0; i < 64; i++) resp_mem[i] = 1'b1;
        run("single", 16'h0001, 1, 16'h0001, -1, -1);

        for (int i = 0; i < 64; i++) resp_mem[i] = 1'b0;
        run("seq3", 16'h0001, 3, 16'h1234, -1, -1);
        run("zero_n", 16'($urandom), 0, 16'h0000, -1, -1);
        run("seed0", 16'h0000, 1, 16'h0000, -1, -1);

        for (int i = 0; i < 64; i++) resp_mem[i] = 1'($urandom);
        run("abort", 16'hACE1, 5, 16'h0000, 2 + PER + 1, -1);
        run("after_abort", 16'hACE1, 5, misr_of(5), -1, -1);
        run("midrst", 16'h1D0F, 3, misr_of(3), -1, 1 + PER);
        run("after_rst", 16'h1D0F, 3, misr_of(3), -1, -1);

        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(0, 12));
            seed = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            for (int i = 0; i < 64; i++) resp_mem[i] = 1'($urandom);
            g = ($urandom_range(0, 1) == 1) ? misr_of(n) : 16'($urandom);
            run("random", seed, n, g, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
